// File: rtl/rob_wide_pkg.sv
// Shared types for the wide reorder buffer: entry kinds, entry
// record and the instruction-length helper.
package rob_wide_pkg;

    typedef enum logic [1:0] {
        ROB_KIND_ALU    = 2'd0,
        ROB_KIND_STORE  = 2'd1,
        ROB_KIND_BRANCH = 2'd2,
        ROB_KIND_JALR   = 2'd3
    } rob_kind_e;

    typedef struct packed {
        logic        valid;
        logic        done;
        rob_kind_e   kind;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        is_c;
        logic        pred;
        logic [31:0] result;
    } rob_entry_t;

    function automatic logic [31:0] inst_len(input logic is_c);
        return is_c ? 32'd2 : 32'd4;
    endfunction

    function automatic logic is_ctrl(input rob_kind_e k);
        return (k == ROB_KIND_BRANCH) || (k == ROB_KIND_JALR);
    endfunction

endpackage

// File: rtl/rob_wide_if.sv
// Allocation, writeback and retirement bundle of the reorder buffer.
// master = instruction unit / CDB side, slave = the ROB.
interface rob_wide_if #(
    parameter int DEPTH    = 16,
    parameter int WB_PORTS = 2,
    parameter int COMMIT_W = 2
);
    localparam int IDX_W = $clog2(DEPTH);

    logic                     alloc_valid_in;
    logic                     alloc_ready_out;
    logic [IDX_W-1:0]         alloc_id_out;
    logic [1:0]               alloc_kind_in;
    logic [4:0]               alloc_rd_in;
    logic [31:0]              alloc_pc_in;
    logic [31:0]              alloc_imm_in;
    logic                     alloc_is_c_in;
    logic                     alloc_pred_in;

    logic [WB_PORTS-1:0]       wb_valid_in;
    logic [WB_PORTS*IDX_W-1:0] wb_id_in;
    logic [WB_PORTS*32-1:0]    wb_val_in;

    logic [COMMIT_W-1:0]       commit_valid_out;
    logic [COMMIT_W*IDX_W-1:0] commit_id_out;
    logic [COMMIT_W*5-1:0]     commit_rd_out;
    logic [COMMIT_W*32-1:0]    commit_val_out;
    logic [COMMIT_W-1:0]       commit_store_out;

    logic                     br_valid_out;
    logic                     br_taken_out;
    logic                     br_correct_out;
    logic                     jalr_valid_out;
    logic [31:0]              jalr_addr_out;
    logic                     flush_out;
    logic [31:0]              flush_pc_out;
    logic [IDX_W:0]           count_out;

    modport master (
        output alloc_valid_in, alloc_kind_in, alloc_rd_in,
               alloc_pc_in, alloc_imm_in, alloc_is_c_in,
               alloc_pred_in, wb_valid_in, wb_id_in, wb_val_in,
        input  alloc_ready_out, alloc_id_out,
               commit_valid_out, commit_id_out, commit_rd_out,
               commit_val_out, commit_store_out,
               br_valid_out, br_taken_out, br_correct_out,
               jalr_valid_out, jalr_addr_out,
               flush_out, flush_pc_out, count_out
    );

    modport slave (
        input  alloc_valid_in, alloc_kind_in, alloc_rd_in,
               alloc_pc_in, alloc_imm_in, alloc_is_c_in,
               alloc_pred_in, wb_valid_in, wb_id_in, wb_val_in,
        output alloc_ready_out, alloc_id_out,
               commit_valid_out, commit_id_out, commit_rd_out,
               commit_val_out, commit_store_out,
               br_valid_out, br_taken_out, br_correct_out,
               jalr_valid_out, jalr_addr_out,
               flush_out, flush_pc_out, count_out
    );

endinterface

// File: rtl/rob_wide_commit_sel.sv
// In-order retire selection over the COMMIT_W entries at the head;
// a control instruction may only retire alone in slot 0.
module rob_commit_sel
    import rob_wide_pkg::*;
#(
    parameter int COMMIT_W = 2,
    parameter int CNT_W    = $clog2(COMMIT_W + 1)
) (
    input  logic [COMMIT_W-1:0] valid,
    input  logic [COMMIT_W-1:0] done,
    input  rob_kind_e           kind [COMMIT_W],
    output logic [COMMIT_W-1:0] mask,
    output logic [CNT_W-1:0]    cnt
);

    logic open;

    always_comb begin
        mask = '0;
        cnt  = '0;
        open = 1'b1;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (open && valid[k] && done[k] &&
                (k == 0 || !is_ctrl(kind[k]))) begin
                mask[k] = 1'b1;
                cnt     = cnt + CNT_W'(1);
            end else begin
                open = 1'b0;
            end
            // nothing may follow a control op in the same cycle
            if (is_ctrl(kind[k])) open = 1'b0;
        end
    end

endmodule

// File: rtl/rob_wide.sv
// Reorder buffer: in-order allocate, multi-port writeback, up to
// COMMIT_W in-order retirements, branch/JALR resolution at the head.
module rob_wide
    import rob_wide_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int WB_PORTS = 2,
    parameter int COMMIT_W = 2
) (
    input logic       clk_in,
    input logic       rst_n_in,
    input logic       rdy_in,
    rob_wide_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int C_W   = IDX_W + 1;
    localparam int CNT_W = $clog2(COMMIT_W + 1);

    rob_entry_t       ent [DEPTH];
    logic [IDX_W-1:0] head, tail;
    logic [C_W-1:0]   count;
    logic             flush_q;

    logic [IDX_W-1:0]    s_idx   [COMMIT_W];
    logic [4:0]          s_rd    [COMMIT_W];
    logic [31:0]         s_val   [COMMIT_W];
    rob_kind_e           s_kind  [COMMIT_W];
    logic [COMMIT_W-1:0] s_valid, s_done, mask;
    logic [CNT_W-1:0]    cnt;

    logic        alloc_acc, head_br, head_jalr, taken, mispred;
    logic [31:0] redirect;

    assign bus.alloc_ready_out = (count < C_W'(DEPTH)) && !flush_q;
    assign bus.alloc_id_out    = tail;
    assign bus.count_out       = count;
    assign bus.flush_out       = flush_q;

    assign alloc_acc = bus.alloc_valid_in && bus.alloc_ready_out && rdy_in;

    always_comb begin
        for (int k = 0; k < COMMIT_W; k++) begin
            s_idx[k]   = head + IDX_W'(k);
            s_valid[k] = rdy_in && ent[s_idx[k]].valid;
            s_done[k]  = ent[s_idx[k]].done;
            s_kind[k]  = ent[s_idx[k]].kind;
            s_rd[k]    = (s_kind[k] == ROB_KIND_STORE ||
                          s_kind[k] == ROB_KIND_BRANCH) ?
                         5'd0 : ent[s_idx[k]].rd;
            s_val[k]   = (s_kind[k] == ROB_KIND_JALR) ?
                         ent[s_idx[k]].pc + inst_len(ent[s_idx[k]].is_c) :
                         ent[s_idx[k]].result;
        end
    end

    rob_commit_sel #(
        .COMMIT_W(COMMIT_W),
        .CNT_W   (CNT_W)
    ) u_sel (
        .valid(s_valid),
        .done (s_done),
        .kind (s_kind),
        .mask (mask),
        .cnt  (cnt)
    );

    assign head_br   = mask[0] && ent[head].kind == ROB_KIND_BRANCH;
    assign head_jalr = mask[0] && ent[head].kind == ROB_KIND_JALR;
    assign taken     = ent[head].result[0];
    assign mispred   = head_br && (ent[head].pred != taken);
    assign redirect  = taken ? ent[head].pc + ent[head].imm :
                               ent[head].pc + inst_len(ent[head].is_c);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i].valid <= 1'b0;
                ent[i].done  <= 1'b0;
            end
            head                 <= '0;
            tail                 <= '0;
            count                <= '0;
            flush_q              <= 1'b0;
            bus.commit_valid_out <= '0;
            bus.commit_id_out    <= '0;
            bus.commit_rd_out    <= '0;
            bus.commit_val_out   <= '0;
            bus.commit_store_out <= '0;
            bus.br_valid_out     <= 1'b0;
            bus.br_taken_out     <= 1'b0;
            bus.br_correct_out   <= 1'b0;
            bus.jalr_valid_out   <= 1'b0;
            bus.jalr_addr_out    <= '0;
            bus.flush_pc_out     <= '0;
        end else begin
            bus.commit_valid_out <= '0;
            bus.commit_store_out <= '0;
            bus.br_valid_out     <= 1'b0;
            bus.jalr_valid_out   <= 1'b0;
            flush_q              <= 1'b0;
            if (rdy_in) begin
                bus.commit_valid_out <= mask;
                for (int k = 0; k < COMMIT_W; k++) begin
                    bus.commit_store_out[k] <=
                        mask[k] && s_kind[k] == ROB_KIND_STORE;
                    if (mask[k]) begin
                        bus.commit_id_out[k*IDX_W +: IDX_W] <= s_idx[k];
                        bus.commit_rd_out[k*5 +: 5]         <= s_rd[k];
                        bus.commit_val_out[k*32 +: 32]      <= s_val[k];
                        ent[s_idx[k]].valid                 <= 1'b0;
                    end
                end
                if (head_br) begin
                    bus.br_valid_out   <= 1'b1;
                    bus.br_taken_out   <= taken;
                    bus.br_correct_out <= !mispred;
                end
                if (head_jalr) begin
                    bus.jalr_valid_out <= 1'b1;
                    bus.jalr_addr_out  <= ent[head].result;
                end
                if (mispred) begin
                    flush_q          <= 1'b1;
                    bus.flush_pc_out <= redirect;
                    for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
                    head  <= '0;
                    tail  <= '0;
                    count <= '0;
                end else begin
                    // later ports overwrite earlier ones on an id clash
                    if (!flush_q) begin
                        for (int p = 0; p < WB_PORTS; p++) begin
                            if (bus.wb_valid_in[p] &&
                                ent[bus.wb_id_in[p*IDX_W +: IDX_W]].valid) begin
                                ent[bus.wb_id_in[p*IDX_W +: IDX_W]].result <=
                                    bus.wb_val_in[p*32 +: 32];
                                ent[bus.wb_id_in[p*IDX_W +: IDX_W]].done <= 1'b1;
                            end
                        end
                    end
                    if (alloc_acc) begin
                        ent[tail] <= '{
                            valid:  1'b1,
                            done:   1'b0,
                            kind:   rob_kind_e'(bus.alloc_kind_in),
                            rd:     bus.alloc_rd_in,
                            pc:     bus.alloc_pc_in,
                            imm:    bus.alloc_imm_in,
                            is_c:   bus.alloc_is_c_in,
                            pred:   bus.alloc_pred_in,
                            result: 32'd0
                        };
                        tail <= tail + IDX_W'(1);
                    end
                    head  <= head + IDX_W'(cnt);
                    count <= count + C_W'(alloc_acc) - C_W'(cnt);
                end
            end
        end
    end

endmodule
